// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mc_pkg;

    // Controller states; IDLE is the reset state and encodes as zero.
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_R_EX,
        S_R_WB,
        S_I_EX,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR
    } state_t;

    // Operation class handed to the ALU control decoder.
    typedef enum logic [2:0] {
        AOP_ADD,
        AOP_SUB,
        AOP_AND,
        AOP_OR,
        AOP_SLT,
        AOP_RFUNC
    } alu_op_t;

    // Opcode field values.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Funct field values for R-type instructions.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU control encodings.
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b111;
    localparam logic [2:0] ALU_UNDEF = 3'b101;

    // Register-file destination select.
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    // PC source select.
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    // ALU operand B select.
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SIMM = 2'b10;
    localparam logic [1:0] SRCB_ZIMM = 2'b11;

endpackage

// File: rtl/alu_ctl_dec.sv
// ALU control decoder: maps an operation class (and, for R-type, the funct
// field) onto the ALU control code. Purely combinational.
module alu_ctl_dec
    import mc_pkg::*;
#(
    parameter int FUNCW = 6
)(
    input  alu_op_t          alu_op,
    input  logic [FUNCW-1:0] func,
    output logic [2:0]       alu_ctl,
    output logic             illegal_func
);

    // Resolve the ALU code; an unknown funct yields the undefined code and a flag
    always_comb begin
        alu_ctl      = ALU_ADD;
        illegal_func = 1'b0;
        case (alu_op)
            AOP_ADD: alu_ctl = ALU_ADD;
            AOP_SUB: alu_ctl = ALU_SUB;
            AOP_AND: alu_ctl = ALU_AND;
            AOP_OR:  alu_ctl = ALU_OR;
            AOP_SLT: alu_ctl = ALU_SLT;
            AOP_RFUNC: begin
                if (func == FUNCW'(FN_ADD)) begin
                    alu_ctl = ALU_ADD;
                end else if (func == FUNCW'(FN_SUB)) begin
                    alu_ctl = ALU_SUB;
                end else if (func == FUNCW'(FN_AND)) begin
                    alu_ctl = ALU_AND;
                end else if (func == FUNCW'(FN_OR)) begin
                    alu_ctl = ALU_OR;
                end else if (func == FUNCW'(FN_SLT)) begin
                    alu_ctl = ALU_SLT;
                end else begin
                    alu_ctl      = ALU_UNDEF;
                    illegal_func = 1'b1;
                end
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared memory port and ALU, with a ready
// handshake for variable-latency memory and a retired-instruction counter.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int FUNCW       = 6,
    parameter int ALUCTLW     = 3,
    parameter int MEM_WAIT_EN = 1,
    parameter int CNTW        = 32
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPW-1:0]     opcode,
    input  logic [FUNCW-1:0]   func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUCTLW-1:0] alu_ctl,
    output logic [1:0]         pc_src,
    output logic               illegal,
    output logic [CNTW-1:0]    retire_cnt
);

    state_t          state_reg;
    logic [CNTW-1:0] retire_cnt_reg;

    state_t          decode_next;
    logic            decode_legal;
    alu_op_t         alu_op;
    logic [2:0]      dec_alu_ctl;
    logic            dec_illegal_func;
    logic            retire;
    logic            mem_ok;

    // With waiting disabled, every access completes in the cycle it is issued
    assign mem_ok = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    logic is_rtype, is_lw, is_sw, is_addi, is_slti, is_andi, is_ori;
    logic is_beq, is_bne, is_j, is_jal, is_jr_fn;

    assign is_rtype = (opcode == OPW'(OP_RTYPE));
    assign is_lw    = (opcode == OPW'(OP_LW));
    assign is_sw    = (opcode == OPW'(OP_SW));
    assign is_addi  = (opcode == OPW'(OP_ADDI));
    assign is_slti  = (opcode == OPW'(OP_SLTI));
    assign is_andi  = (opcode == OPW'(OP_ANDI));
    assign is_ori   = (opcode == OPW'(OP_ORI));
    assign is_beq   = (opcode == OPW'(OP_BEQ));
    assign is_bne   = (opcode == OPW'(OP_BNE));
    assign is_j     = (opcode == OPW'(OP_J));
    assign is_jal   = (opcode == OPW'(OP_JAL));
    assign is_jr_fn = (func == FUNCW'(FN_JR));

    // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH
    always_comb begin
        decode_next  = S_FETCH;
        decode_legal = 1'b1;
        if (is_rtype) begin
            decode_next = is_jr_fn ? S_JR : S_R_EX;
        end else if (is_lw || is_sw) begin
            decode_next = S_MEM_ADDR;
        end else if (is_addi || is_slti || is_andi || is_ori) begin
            decode_next = S_I_EX;
        end else if (is_beq || is_bne) begin
            decode_next = S_BRANCH;
        end else if (is_j) begin
            decode_next = S_JUMP;
        end else if (is_jal) begin
            decode_next = S_JAL;
        end else begin
            decode_legal = 1'b0;
        end
    end

    // ALU operation class per state; kept apart from the output block so the
    // decoder's illegal flag does not feed back into its own input
    always_comb begin
        alu_op = AOP_ADD;
        case (state_reg)
            S_R_EX: alu_op = AOP_RFUNC;
            S_I_EX: begin
                if (is_slti) begin
                    alu_op = AOP_SLT;
                end else if (is_andi) begin
                    alu_op = AOP_AND;
                end else if (is_ori) begin
                    alu_op = AOP_OR;
                end else begin
                    alu_op = AOP_ADD;
                end
            end
            S_BRANCH: alu_op = AOP_SUB;
            default:  alu_op = AOP_ADD;
        endcase
    end

    alu_ctl_dec #(
        .FUNCW (FUNCW)
    ) u_alu_ctl_dec (
        .alu_op       (alu_op),
        .func         (func),
        .alu_ctl      (dec_alu_ctl),
        .illegal_func (dec_illegal_func)
    );

    assign alu_ctl = ALUCTLW'(dec_alu_ctl);

    // Moore-style control outputs; write enables during waits stay low
    always_comb begin
        pc_we     = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = RD_RT;
        wd_sel    = WD_ALUOUT;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_B;
        pc_src    = PCS_ALU;
        illegal   = 1'b0;
        retire    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ok) begin
                    ir_write = 1'b1;
                    pc_we    = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_SIMM;
                illegal   = ~decode_legal;
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                illegal   = dec_illegal_func;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
                retire    = 1'b1;
            end
            S_I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = (is_andi || is_ori) ? SRCB_ZIMM : SRCB_SIMM;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SIMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wd_sel    = WD_MDR;
                retire    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ok;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = PCS_ALUOUT;
                pc_we     = is_beq ? zero : ~zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src = PCS_JUMP;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            S_JAL: begin
                pc_src    = PCS_JUMP;
                pc_we     = 1'b1;
                reg_write = 1'b1;
                reg_dst   = RD_R31;
                wd_sel    = WD_PC;
                retire    = 1'b1;
            end
            S_JR: begin
                pc_src = PCS_REGA;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    // State sequencing and retired-instruction counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            retire_cnt_reg <= '0;
        end else begin
            if (retire) begin
                retire_cnt_reg <= retire_cnt_reg + CNTW'(1);
            end
            case (state_reg)
                S_IDLE:     state_reg <= S_FETCH;
                S_FETCH:    if (mem_ok) state_reg <= S_DECODE;
                S_DECODE:   state_reg <= decode_next;
                S_R_EX:     state_reg <= S_R_WB;
                S_I_EX:     state_reg <= S_I_WB;
                S_MEM_ADDR: state_reg <= is_lw ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ok) state_reg <= S_MEM_WB;
                S_MEM_WR:   if (mem_ok) state_reg <= S_FETCH;
                S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                            state_reg <= S_FETCH;
                default:    state_reg <= S_IDLE;
            endcase
        end
    end

    assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: walks instruction sequences
// cycle by cycle and compares the full control vector against hand-derived
// values for each state.
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        zero;
    logic        mem_ready;

    logic        pc_we, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  reg_dst, wd_sel, alu_src_b, pc_src;
    logic        alu_src_a, illegal;
    logic [2:0]  alu_ctl;
    logic [31:0] retire_cnt;

    logic        pc_we_0, i_or_d_0, mem_read_0, mem_write_0, ir_write_0, reg_write_0;
    logic [1:0]  reg_dst_0, wd_sel_0, alu_src_b_0, pc_src_0;
    logic        alu_src_a_0, illegal_0;
    logic [2:0]  alu_ctl_0;
    logic [31:0] retire_cnt_0;

    int n_cmp;
    int n_err;
    int n_irw;
    int n_mdr;

    multicycle_controller #(
        .OPW(6), .FUNCW(6), .ALUCTLW(3), .MEM_WAIT_EN(1), .CNTW(32)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
        .pc_src(pc_src), .illegal(illegal), .retire_cnt(retire_cnt)
    );

    // Second instance: memory waiting disabled, mem_ready tied low
    multicycle_controller #(
        .OPW(6), .FUNCW(6), .ALUCTLW(3), .MEM_WAIT_EN(0), .CNTW(32)
    ) u_dut_nowait (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(1'b0), .pc_we(pc_we_0), .i_or_d(i_or_d_0),
        .mem_read(mem_read_0), .mem_write(mem_write_0), .ir_write(ir_write_0),
        .reg_write(reg_write_0), .reg_dst(reg_dst_0), .wd_sel(wd_sel_0),
        .alu_src_a(alu_src_a_0), .alu_src_b(alu_src_b_0), .alu_ctl(alu_ctl_0),
        .pc_src(pc_src_0), .illegal(illegal_0), .retire_cnt(retire_cnt_0)
    );

    logic [18:0] ctl;
    logic [18:0] ctl_0;
    assign ctl   = {pc_we, i_or_d, mem_read, mem_write, ir_write, reg_write,
                    reg_dst, wd_sel, alu_src_a, alu_src_b, alu_ctl, pc_src, illegal};
    assign ctl_0 = {pc_we_0, i_or_d_0, mem_read_0, mem_write_0, ir_write_0, reg_write_0,
                    reg_dst_0, wd_sel_0, alu_src_a_0, alu_src_b_0, alu_ctl_0, pc_src_0, illegal_0};

    // Packs the control outputs in the same order as ctl
    function automatic logic [18:0] mk(
        input logic pw, input logic io, input logic mr, input logic mw,
        input logic irw, input logic rw, input logic [1:0] rd, input logic [1:0] wd,
        input logic sa, input logic [1:0] sb, input logic [2:0] ac,
        input logic [1:0] ps, input logic il);
        return {pw, io, mr, mw, irw, rw, rd, wd, sa, sb, ac, ps, il};
    endfunction

    //                              pw io mr mw ir rw rd     wd     sa sb     alu     ps     il
    localparam logic [18:0] E_IDLE       = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_FETCH      = mk(1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_FETCH_WAIT = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_DECODE     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_DECODE_ILL = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10, 3'b010, 2'b00, 1);
    localparam logic [18:0] E_R_EX_ADD   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_R_EX_BAD   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b101, 2'b00, 1);
    localparam logic [18:0] E_R_WB       = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_I_EX_ORI   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b11, 3'b001, 2'b00, 0);
    localparam logic [18:0] E_I_WB       = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_MEM_ADDR   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_MEM_RD     = mk(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_MEM_WB     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_MEM_WR     = mk(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [18:0] E_BR_TAKEN   = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b110, 2'b01, 0);
    localparam logic [18:0] E_BR_NOT     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b110, 2'b01, 0);
    localparam logic [18:0] E_JAL        = mk(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 3'b010, 2'b10, 0);
    localparam logic [18:0] E_JR         = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b010, 2'b11, 0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic sample(input string tag, input logic [18:0] exp);
        #1;
        check_val(tag, {13'b0, ctl}, {13'b0, exp});
        if (ir_write) n_irw++;
        if (reg_write && (wd_sel == 2'b01)) n_mdr++;
    endtask

    // One clock of the current instruction with the given mem_ready
    task automatic cyc(input string tag, input logic mr, input logic [18:0] exp);
        @(negedge clk);
        mem_ready = mr;
        sample(tag, exp);
    endtask

    // First (FETCH) cycle of a new instruction; loads the IR fields
    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr, input logic [18:0] exp);
        @(negedge clk);
        opcode    = op;
        func      = fn;
        zero      = z;
        mem_ready = mr;
        sample(tag, exp);
    endtask

    task automatic cyc_nowait(input string tag, input logic [18:0] exp);
        @(negedge clk);
        #1;
        check_val(tag, {13'b0, ctl_0}, {13'b0, exp});
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_irw = 0; n_mdr = 0;
        opcode = 6'b000000; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ctl", {13'b0, ctl}, {13'b0, E_IDLE});
        check_val("rst_cnt", retire_cnt, 32'd0);

        // add: IDLE, FETCH, DECODE, R_EX, R_WB
        @(negedge clk);
        rst_n = 1'b1;
        sample("add_idle", E_IDLE);
        cyc("add_fetch", 1'b1, E_FETCH);
        cyc("add_dec",   1'b1, E_DECODE);
        cyc("add_rex",   1'b1, E_R_EX_ADD);
        cyc("add_rwb",   1'b1, E_R_WB);

        // lw with 2 FETCH waits and 3 MEM_RD waits: 10 cycles
        n_irw = 0; n_mdr = 0;
        fetch("lw_fwait1", 6'b100011, 6'b000000, 1'b0, 1'b0, E_FETCH_WAIT);
        check_val("cnt_after_add", retire_cnt, 32'd1);
        cyc("lw_fwait2", 1'b0, E_FETCH_WAIT);
        cyc("lw_fetch",  1'b1, E_FETCH);
        cyc("lw_dec",    1'b1, E_DECODE);
        cyc("lw_addr",   1'b1, E_MEM_ADDR);
        cyc("lw_rwait1", 1'b0, E_MEM_RD);
        cyc("lw_rwait2", 1'b0, E_MEM_RD);
        cyc("lw_rwait3", 1'b0, E_MEM_RD);
        cyc("lw_rd",     1'b1, E_MEM_RD);
        cyc("lw_wb",     1'b1, E_MEM_WB);
        check_val("lw_irw_pulses", n_irw, 32'd1);
        check_val("lw_mdr_writes", n_mdr, 32'd1);

        // beq taken, bne not taken (zero = 1 for both)
        fetch("beq_fetch", 6'b000100, 6'b000000, 1'b1, 1'b1, E_FETCH);
        check_val("cnt_after_lw", retire_cnt, 32'd2);
        cyc("beq_dec", 1'b1, E_DECODE);
        cyc("beq_br",  1'b1, E_BR_TAKEN);
        fetch("bne_fetch", 6'b000101, 6'b000000, 1'b1, 1'b1, E_FETCH);
        check_val("cnt_after_beq", retire_cnt, 32'd3);
        cyc("bne_dec", 1'b1, E_DECODE);
        cyc("bne_br",  1'b1, E_BR_NOT);

        // jal then jr: 3 + 3 cycles
        fetch("jal_fetch", 6'b000011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        check_val("cnt_after_bne", retire_cnt, 32'd4);
        cyc("jal_dec", 1'b1, E_DECODE);
        cyc("jal_ex",  1'b1, E_JAL);
        fetch("jr_fetch", 6'b000000, 6'b001000, 1'b0, 1'b1, E_FETCH);
        check_val("cnt_after_jal", retire_cnt, 32'd5);
        cyc("jr_dec", 1'b1, E_DECODE);
        cyc("jr_ex",  1'b1, E_JR);

        // ori: zero-extended immediate, OR
        fetch("ori_fetch", 6'b001101, 6'b000000, 1'b0, 1'b1, E_FETCH);
        check_val("cnt_after_jr", retire_cnt, 32'd6);
        cyc("ori_dec", 1'b1, E_DECODE);
        cyc("ori_ex",  1'b1, E_I_EX_ORI);
        cyc("ori_wb",  1'b1, E_I_WB);

        // Illegal opcode: pulse in DECODE, back to FETCH, not retired
        fetch("ill_fetch", 6'b111111, 6'b000000, 1'b0, 1'b1, E_FETCH);
        check_val("cnt_after_ori", retire_cnt, 32'd7);
        cyc("ill_dec", 1'b1, E_DECODE_ILL);

        // R-type with unknown funct: undefined ALU code and illegal in R_EX
        fetch("badfn_fetch", 6'b000000, 6'b000111, 1'b0, 1'b1, E_FETCH);
        check_val("cnt_after_ill", retire_cnt, 32'd7);
        cyc("badfn_dec", 1'b1, E_DECODE);
        cyc("badfn_rex", 1'b1, E_R_EX_BAD);
        cyc("badfn_rwb", 1'b1, E_R_WB);

        // sw stalled in MEM_WR, then async reset aborts it
        fetch("sw_fetch", 6'b101011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        cyc("sw_dec",    1'b1, E_DECODE);
        cyc("sw_addr",   1'b1, E_MEM_ADDR);
        cyc("sw_wwait1", 1'b0, E_MEM_WR);
        cyc("sw_wwait2", 1'b0, E_MEM_WR);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_mem_write", {31'b0, mem_write}, 32'd0);
        check_val("abort_ctl", {13'b0, ctl}, {13'b0, E_IDLE});
        check_val("abort_cnt", retire_cnt, 32'd0);

        // No-wait instance: sw completes in 4 cycles with mem_ready tied low
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 6'b101011;
        func   = 6'b000000;
        #1;
        check_val("nw_idle", {13'b0, ctl_0}, {13'b0, E_IDLE});
        cyc_nowait("nw_fetch", E_FETCH);
        cyc_nowait("nw_dec",   E_DECODE);
        cyc_nowait("nw_addr",  E_MEM_ADDR);
        cyc_nowait("nw_wr",    E_MEM_WR);
        cyc_nowait("nw_next",  E_FETCH);
        check_val("nw_cnt", retire_cnt_0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS controller. It contains a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks. Sequencing shares one memory port and one ALU, and uses a ready handshake so that variable-latency memory can stall the machine. It sits beside the multi-cycle datapath, drives every mux, enable and ALU-control line, and counts retired instructions.

Parameters:
OPW, 6, opcode field width
FUNCW, 6, funct field width
ALUCTLW, 3, ALU control width
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat memory as single-cycle (mem_ready ignored, taken as 1)
CNTW, 32, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
opcode  in  OPW  IR[31:26]
func  in  FUNCW  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes the current access this cycle
pc_we  out  1  PC write enable (unconditional or resolved branch)
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register
reg_write  out  1  register-file write
reg_dst  out  2  00 rt, 01 rd, 10 r31
wd_sel  out  2  00 ALUOut, 01 MDR, 10 PC (link)
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 zero-ext imm
alu_ctl  out  ALUCTLW  010 add, 110 sub, 000 and, 001 or, 111 slt, 101 undefined
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A
illegal  out  1  one-cycle pulse on an unsupported opcode/func
retire_cnt  out  CNTW  instructions completed since reset

Behaviour:
- Reset (rst_n low, async): state = IDLE, retire_cnt = 0. In IDLE every output is 0 except alu_ctl = 010. IDLE advances to FETCH on the first clock after release.
- FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_ctl = add, pc_src = 00.
  - ir_write and pc_we assert only in a cycle where mem_ready = 1; the FSM holds in FETCH otherwise.
  - On mem_ready -> DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 10, alu_ctl = add (branch target into ALUOut). Dispatch on opcode:
  - 000000 with func 001000 -> JR
  - other 000000 -> R_EX
  - 100011 / 101011 -> MEM_ADDR
  - 001000, 001010, 001100, 001101 -> I_EX
  - 000100 / 000101 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - anything else -> FETCH with illegal = 1 for that cycle (instruction skipped, not retired)
- R_EX: alu_src_a = 1, alu_src_b = 00, alu_ctl from func (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, else 101 and illegal = 1) -> R_WB.
- R_WB: reg_write = 1, reg_dst = 01, wd_sel = 00; retire -> FETCH.
- I_EX: alu_src_a = 1.
  - addi/slti: alu_src_b = 10. andi/ori: alu_src_b = 11.
  - alu_ctl: addi add, slti slt, andi and, ori or.
  - -> I_WB.
- I_WB: reg_write = 1, reg_dst = 00, wd_sel = 00; retire -> FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, add. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 00, wd_sel = 01; retire -> FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1. Hold until mem_ready, then retire -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01.
  - pc_we = zero for beq, ~zero for bne.
  - Retire -> FETCH.
- JUMP: pc_src = 10, pc_we = 1; retire -> FETCH.
- JAL: pc_src = 10, pc_we = 1, reg_write = 1, reg_dst = 10, wd_sel = 10; retire -> FETCH. PC is written at the end of the cycle, so the link value is PC+4.
- JR: pc_src = 11, pc_we = 1; retire -> FETCH.
- Cycle counts with mem_ready always 1:
  - 3 cycles: beq/bne/j/jal/jr
  - 4 cycles: R-type, I-type, sw
  - 5 cycles: lw
  - Each wait cycle adds 1.
- retire_cnt increments by 1 on the final cycle of each legal instruction and wraps modulo 2^CNTW.
- mem_read/mem_write stay asserted and stable through wait cycles. No write enable (pc_we, ir_write, reg_write) asserts during a wait.
- Reset asserted mid-instruction aborts it with no further enables; that instruction is not counted.
- Outputs are combinational from the state register plus opcode/func/zero/mem_ready only. No latches; every output is defaulted each cycle.

Decomposition:
- Package mc_pkg: state enum, opcode/func constants, alu_ctl encodings, reg_dst/wd_sel/pc_src/alu_src_b encodings.
- One sub-module, alu_ctl_dec: pure combinational; maps (alu op class, func) to alu_ctl plus an illegal-func flag. Reused by R_EX and I_EX.

Test Plan:
- Reset release, opcode 000000/func 100000, mem_ready = 1 -> states IDLE, FETCH, DECODE, R_EX, R_WB. reg_write = 1, reg_dst = 01 in cycle 4; retire_cnt = 1.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total. ir_write pulses once; reg_write with wd_sel = 01 exactly once.
- beq with zero = 1 -> pc_we = 1, pc_src = 01 in BRANCH. bne with zero = 1 -> pc_we = 0. Both retire.
- jal -> single cycle with pc_we = 1, reg_dst = 10, wd_sel = 10, pc_src = 10. Then jr (func 001000) -> pc_src = 11, pc_we = 1; total 6 cycles.
- Opcode 111111 -> illegal pulses in DECODE, returns to FETCH, retire_cnt unchanged. R-type with func 000111 -> alu_ctl = 101 and illegal pulses in R_EX.
- rst_n dropped in MEM_WR while mem_ready = 0 -> mem_write falls immediately, state IDLE, retire_cnt = 0. With MEM_WAIT_EN = 0, the sw completes in 4 cycles with mem_ready tied 0.
